// File: rtl/fetch_order_module.sv
// Fetch stage: holds the PC, issues one bus read per fetch_start, returns word + PC (bus timeout: FETCH_BUS_TIMEOUT_EN).
// Latency: out_valid two cycles after fetch_start on a zero-wait bus; at most one fetch per two cycles.
// Backpressure: waits on inst_ack with inst_req held; fetch_ready low while a fetch or drain is open.
module fetch_order_module #(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              fetch_clean,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              fetch_ready,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic [31:0]       inst_rdata,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              timeout_hit;

`ifdef FETCH_BUS_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W    = (CNT_BITS > 8) ? CNT_BITS : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;
  logic             to_drain;

  // Entering DRAIN restarts the wait window, so a clean never shortens it.
  assign to_drain    = (state == REQ) && fetch_clean && !inst_ack;
  assign timeout_hit = (state != IDLE) && !inst_ack && !to_drain &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      fault_q <= timeout_hit;
      if (state == IDLE || to_drain || timeout_hit)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign fetch_fault    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      fetch_ready <= 1'b1;
      inst_req    <= 1'b0;
      inst_addr   <= RESET_PC;
      out_valid   <= 1'b0;
      out_inst    <= '0;
      out_pc      <= RESET_PC;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_start && !fetch_clean) begin
            state       <= REQ;
            inst_req    <= 1'b1;
            inst_addr   <= pc;
            fetch_ready <= 1'b0;
          end
        end
        REQ: begin
          if (inst_ack) begin
            state       <= IDLE;
            inst_req    <= 1'b0;
            fetch_ready <= 1'b1;
            if (!fetch_clean) begin
              out_inst  <= inst_rdata;
              out_pc    <= inst_addr;
              out_valid <= 1'b1;
              pc        <= inst_addr + ADDR_W'(4);
            end
          end else if (fetch_clean) begin
            state <= DRAIN;
          end else if (timeout_hit) begin
            state       <= IDLE;
            inst_req    <= 1'b0;
            fetch_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (inst_ack || timeout_hit) begin
            state       <= IDLE;
            inst_req    <= 1'b0;
            fetch_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Redirect wins over the +4 advance made above in the same cycle.
      if (pc_load)
        pc <= pc_load_value;
    end
  end

endmodule

// File: tb/tb_fetch_order_module.sv
// Bench for fetch_order_module: transaction-level model checked every cycle plus directed literal checks.
module tb_fetch_order_module;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start, fetch_clean, pc_load;
  logic [31:0] pc_load_value;
  logic        fetch_ready, inst_req, inst_ack;
  logic [31:0] inst_addr, inst_rdata, out_inst, out_pc;
  logic        out_valid, fetch_fault;

  always #5 clk = ~clk;

  fetch_order_module #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .fetch_clean(fetch_clean),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .fetch_ready(fetch_ready),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: acks after ack_delay wait cycles, data derived from the address.
  int ack_delay = 0;
  int bus_wait  = 0;
  initial begin
    inst_ack   = 1'b0;
    inst_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (inst_req) begin
        if (bus_wait >= ack_delay) begin
          inst_ack   = 1'b1;
          inst_rdata = 32'hA000_0001 + (inst_addr >> 2);
          bus_wait   = 0;
        end else begin
          inst_ack   = 1'b0;
          inst_rdata = 32'hDEAD_BEEF;
          bus_wait++;
        end
      end else begin
        inst_ack = 1'b0;
        bus_wait = 0;
      end
    end
  end

  // Delivered results and fault pulses, as seen by the next stage.
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          fault_cnt = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      got_pc.push_back(out_pc);
      got_inst.push_back(out_inst);
    end
    if (fetch_fault) fault_cnt++;
  end

  // Model: a fetch is either absent, live, or dropped (aborted but still owed an ack).
  logic        m_busy = 1'b0, m_drop = 1'b0, m_valid = 1'b0, m_fault = 1'b0;
  logic [31:0] m_pc = 32'h0, m_addr = 32'h0, m_inst = 32'h0, m_opc = 32'h0, npc = 32'h0;
  int          m_wait = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 1'b0; m_drop = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
      m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0; m_opc = 32'h0; m_wait = 0;
    end else begin
      npc = m_pc;
      m_valid = 1'b0;
      m_fault = 1'b0;
      if (!m_busy) begin
        if (fetch_start && !fetch_clean) begin
          m_busy = 1'b1; m_drop = 1'b0; m_addr = m_pc; m_wait = 0;
        end
      end else if (inst_ack) begin
        if (!m_drop && !fetch_clean) begin
          m_inst = inst_rdata; m_opc = m_addr; m_valid = 1'b1; npc = m_addr + 32'd4;
        end
        m_busy = 1'b0;
      end else if (!m_drop && fetch_clean) begin
        m_drop = 1'b1;
        m_wait = 0;
      end else begin
        m_wait++;
`ifdef FETCH_BUS_TIMEOUT_EN
        if (m_wait == TMO) begin
          m_busy = 1'b0;
          m_fault = 1'b1;
        end
`endif
      end
      if (pc_load) npc = pc_load_value;
      m_pc = npc;
    end
    #1;
    check("fetch_ready", 32'(fetch_ready), 32'(!m_busy));
    check("inst_req",    32'(inst_req),    32'(m_busy));
    check("inst_addr",   inst_addr,        m_addr);
    check("out_valid",   32'(out_valid),   32'(m_valid));
    check("out_inst",    out_inst,         m_inst);
    check("out_pc",      out_pc,           m_opc);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
  end

  task automatic do_reset();
    rst = 1'b0; fetch_start = 1'b0; fetch_clean = 1'b0; pc_load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    got_pc.delete();
    got_inst.delete();
  endtask

  initial begin
    int req_cycles;
    logic loaded, seen;
    logic [31:0] after_addr;

    rst = 1'b0; fetch_start = 1'b0; fetch_clean = 1'b0; pc_load = 1'b0; pc_load_value = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(fetch_ready), 32'd1);
    check("rst_req",   32'(inst_req),    32'd0);
    check("rst_addr",  inst_addr,        32'h0);
    check("rst_outpc", out_pc,           32'h0);
    check("rst_valid", 32'(out_valid),   32'd0);

    // Zero-wait bus, fetch_start held: a result every second cycle.
    rst = 1'b1; ack_delay = 0; fetch_start = 1'b1;
    repeat (4) @(negedge clk);
    fetch_start = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_count", got_pc.size(), 2);
    if (got_pc.size() >= 2) begin
      check("b2b_pc0",   got_pc[0],   32'h0);
      check("b2b_inst0", got_inst[0], 32'hA000_0001);
      check("b2b_pc1",   got_pc[1],   32'h4);
      check("b2b_inst1", got_inst[1], 32'hA000_0002);
    end

    // Ack after 5 wait cycles: request held 6 cycles, one result.
    do_reset();
    ack_delay = 5; fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    req_cycles = 0;
    repeat (15) begin
      if (inst_req) req_cycles++;
      @(negedge clk);
    end
    check("slow_req_cycles", req_cycles, 6);
    check("slow_count", got_pc.size(), 1);
    if (got_pc.size() >= 1) check("slow_pc", got_pc[0], 32'h0);

    // Clean in the second wait cycle: drain, no result, same PC refetched.
    do_reset();
    ack_delay = 5; fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      if (inst_req) req_cycles++;
      fetch_clean = (i == 1);
      @(negedge clk);
    end
    check("drain_req_cycles", req_cycles, 6);
    check("drain_count", got_pc.size(), 0);
    ack_delay = 0; fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    repeat (3) @(negedge clk);
    check("refetch_count", got_pc.size(), 1);
    if (got_pc.size() >= 1) check("refetch_pc", got_pc[0], 32'h0);

    // Redirect in the same cycle as the ack at PC 8.
    do_reset();
    ack_delay = 0; fetch_start = 1'b1;
    loaded = 1'b0; seen = 1'b0; after_addr = 32'h0;
    for (int i = 0; i < 30 && !seen; i++) begin
      pc_load = 1'b0;
      if (inst_req && inst_addr == 32'h8 && !loaded) begin
        pc_load = 1'b1; pc_load_value = 32'h0000_1000; loaded = 1'b1;
      end else if (loaded && inst_req) begin
        after_addr = inst_addr; seen = 1'b1; fetch_start = 1'b0;
      end
      @(negedge clk);
    end
    fetch_start = 1'b0;
    pc_load = 1'b0;
    check("redir_seen", 32'(seen), 32'd1);
    check("redir_addr", after_addr, 32'h0000_1000);
    repeat (3) @(negedge clk);
    if (got_pc.size() >= 3) check("redir_outpc", got_pc[2], 32'h8);
    else check("redir_count", got_pc.size(), 3);

    // PC wrap from the top of the address space.
    do_reset();
    pc_load = 1'b1; pc_load_value = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0; fetch_start = 1'b1;
    repeat (4) @(negedge clk);
    fetch_start = 1'b0;
    repeat (2) @(negedge clk);
    check("wrap_count", got_pc.size(), 2);
    if (got_pc.size() >= 2) begin
      check("wrap_pc0",   got_pc[0],   32'hFFFF_FFFC);
      check("wrap_pc1",   got_pc[1],   32'h0);
      check("wrap_inst1", got_inst[1], 32'hA000_0001);
    end

`ifdef FETCH_BUS_TIMEOUT_EN
    // Bus never acks: fault after TMO request cycles, PC kept.
    do_reset();
    ack_delay = 1000; fault_cnt = 0; fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    req_cycles = 0;
    repeat (10) begin
      if (inst_req) req_cycles++;
      @(negedge clk);
    end
    check("tmo_req_cycles", req_cycles, TMO);
    check("tmo_faults", fault_cnt, 1);
    check("tmo_count", got_pc.size(), 0);
    ack_delay = 0; fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    repeat (3) @(negedge clk);
    if (got_pc.size() >= 1) check("tmo_pc_kept", got_pc[0], 32'h0);
    else check("tmo_refetch_count", got_pc.size(), 1);
`endif

    // Reset while a request is open, then while draining.
    do_reset();
    ack_delay = 1000;
    pc_load = 1'b1; pc_load_value = 32'h40;
    @(negedge clk);
    pc_load = 1'b0; fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    repeat (2) @(negedge clk);
    check("midreq_req",  32'(inst_req), 32'd1);
    check("midreq_addr", inst_addr,     32'h40);
    rst = 1'b0;
    @(negedge clk);
    check("rstreq_req",   32'(inst_req),    32'd0);
    check("rstreq_ready", 32'(fetch_ready), 32'd1);
    check("rstreq_addr",  inst_addr,        32'h0);
    rst = 1'b1; fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0; fetch_clean = 1'b1;
    @(negedge clk);
    fetch_clean = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rstdrain_req", 32'(inst_req), 32'd0);
    ack_delay = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
